// File: rtl/channel_pipelined_adds_pkg.sv
// Shared defaults and types for the channel_pipelined_adds datapath slice.
package channel_pipelined_adds_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int STAGE_INCR_DEF = 1;
    localparam int NUM_STAGES     = 2;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    localparam data_t RESET_VALUE = '0;

endpackage

// File: rtl/channel_add_stage.sv
// Combinational channel stage: adds a constant to the data and passes the valid through.
module channel_add_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int INCR       = 1
) (
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    // Carry out of the stage is discarded: modulo 2^DATA_WIDTH.
    assign out_data  = in_data + DATA_WIDTH'(INCR);
    assign out_valid = in_valid;

endmodule

// File: rtl/channel_pipelined_adds.sv
// Valid-qualified +2 datapath: two chained add stages feeding a single enabled output register.
module channel_pipelined_adds
    import channel_pipelined_adds_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STAGE_INCR = STAGE_INCR_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] result
);

    logic [NUM_STAGES:0]                 stage_valid;
    logic [NUM_STAGES:0][DATA_WIDTH-1:0] stage_data;
    logic [DATA_WIDTH-1:0]               result_reg;

    assign stage_valid[0] = in_valid;
    assign stage_data[0]  = in_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            channel_add_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .INCR       (STAGE_INCR)
            ) u_stage (
                .in_valid  (stage_valid[gi]),
                .in_data   (stage_data[gi]),
                .out_valid (stage_valid[gi+1]),
                .out_data  (stage_data[gi+1])
            );
        end
    endgenerate

    // Reset wins over a valid sample; the data path is only sampled when valid,
    // so don't-care input data never reaches the register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_reg <= DATA_WIDTH'(RESET_VALUE);
        end else if (stage_valid[NUM_STAGES]) begin
            result_reg <= stage_data[NUM_STAGES];
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_channel_pipelined_adds.sv
// Table-driven bench for channel_pipelined_adds plus hand-written latency and hold sequences.
module tb_channel_pipelined_adds;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] result;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    channel_pipelined_adds #(
        .DATA_WIDTH (16),
        .STAGE_INCR (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: result=0x%04h ok", name, act);
        end else begin
            $display("FAIL %s: result=0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        //          rst   vld   data      expected result after the edge
        vecs[0]  = '{1'b0, 1'b1, 16'd50,   16'd0};
        vecs[1]  = '{1'b1, 1'b1, 16'd10,   16'd12};
        vecs[2]  = '{1'b1, 1'b1, 16'd15,   16'd17};
        vecs[3]  = '{1'b1, 1'b0, 16'd18,   16'd17};
        vecs[4]  = '{1'b1, 1'b0, 16'd18,   16'd17};
        vecs[5]  = '{1'b1, 1'b0, 16'd18,   16'd17};
        vecs[6]  = '{1'b1, 1'b1, 16'hFFFE, 16'h0000};
        vecs[7]  = '{1'b1, 1'b1, 16'hFFFF, 16'h0001};
        vecs[8]  = '{1'b1, 1'b1, 16'd15,   16'd17};
        vecs[9]  = '{1'b0, 1'b1, 16'd99,   16'd0};
        vecs[10] = '{1'b1, 1'b1, 16'd3,    16'd5};
        vecs[11] = '{1'b1, 1'b1, 16'h7FFF, 16'h8001};

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            in_valid = vecs[i].vld;
            in_data  = vecs[i].data;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d rst=%0b vld=%0b data=0x%04h", i, vecs[i].rst, vecs[i].vld,
                            vecs[i].data), result, vecs[i].exp);
        end

        // No combinational path: a new valid input must not show before the edge.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd100;
        #1;
        check("no_comb_path_pre_edge", result, 16'h8001);
        @(posedge clk);
        #1;
        check("latency_one_edge", result, 16'd102);

        // Long hold with changing don't-care data while invalid.
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_data = 16'(k * 4099);
            @(posedge clk);
            #1;
            check($sformatf("hold_invalid_%0d", k), result, 16'd102);
            @(negedge clk);
        end

        // Back-to-back valid burst, one update per edge.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'd1000 + k);
            @(posedge clk);
            #1;
            check($sformatf("burst_%0d", k), result, 16'(16'd1002 + k));
            @(negedge clk);
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/channel_pipelined_adds.md
# channel_pipelined_adds

Adds the constant 2 to each valid 16-bit sample on a valid-qualified input channel and holds the latest sum in a registered output. The add is built as two chained +1 adder stages, and the output register is the only storage. The block is a small datapath leaf. It is used as a reference for channel-style (valid-qualified) dataflow composition and sits between a producer channel and any consumer that samples `result`.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: width of `in_data` and `result`.
- `STAGE_INCR`, default 1: constant added by each of the two adder stages. Total increment is 2 × `STAGE_INCR`.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-low. Sampled only on the rising edge of `clk`; `rst == 0` resets.
- `in_valid`, input, 1: qualifies `in_data` for the current cycle.
- `in_data`, input, `DATA_WIDTH`: input sample.
- `result`, output, `DATA_WIDTH`: registered sum of the last accepted sample plus 2.

## Operation
- Stage 1 computes `s1 = in_data + STAGE_INCR` combinationally.
- Stage 2 computes `s2 = s1 + STAGE_INCR` combinationally.
- Output register behaviour at each rising edge of `clk`:
  - `rst == 0`: `result <= 0`.
  - Otherwise, `in_valid == 1`: `result <= s2`.
  - Otherwise: `result` holds its value.
- Arithmetic is unsigned, modulo 2^`DATA_WIDTH`. Carries out of each stage are discarded.
  - 0xFFFE → 0x0000.
  - 0xFFFF → 0x0001.
- No backpressure and no ready signal. Every valid cycle is accepted unconditionally.
- When `in_valid == 0`, `in_data` is don't-care. X on `in_data` must not propagate into `result`.

## Timing
- Latency: 1 clock edge. A sample presented with `in_valid == 1` before edge N is visible on `result` immediately after edge N.
- Throughput: one sample per cycle. Back-to-back valid cycles each update `result`.
- Reset value of `result`: 0.
- Reset has priority over `in_valid`. A valid sample in a reset cycle is dropped.
- Reset mid-stream: `result` reads 0 after the reset edge. The first valid sample after reset is deasserted updates it normally.
- `in_valid` dropping after valid data: `result` keeps the last sum indefinitely.
- No combinational path from any input to `result`.

## Structure
- Sub-module `channel_add_stage`:
  - Parameters: `DATA_WIDTH`, `INCR`.
  - Ports: `in_valid`, `in_data`, `out_valid`, `out_data`.
  - Purely combinational: `out_data = in_data + INCR`, `out_valid = in_valid`.
  - Instantiated twice in series. The second stage's `out_valid` drives the register enable.
- Shared package holds:
  - `DATA_WIDTH` default (16).
  - `STAGE_INCR` default (1).
  - A `data_t` typedef for the `DATA_WIDTH`-bit logic vector.
  - The reset value constant (0).

## Test plan
- Reset: drive `rst = 0` for one edge with `in_valid = 1`, `in_data = 50` → `result == 0`.
- Single sample: `rst = 1`, `in_valid = 1`, `in_data = 10`, one edge → `result == 12`.
- Back-to-back samples: `in_data = 10` then `15`, both valid, on consecutive edges → `result == 12`, then `17`.
- Hold on invalid: after `result == 17`, set `in_valid = 0`, `in_data = 18`, clock 3 edges → `result` stays 17.
- Wrap-around: valid `in_data = 0xFFFE` → `0x0000`; valid `in_data = 0xFFFF` → `0x0001`.
- Reset mid-stream: with `result == 17`, assert `rst = 0` for one edge → 0. Release and send valid `in_data = 3` → `result == 5`.
